// File: rtl/nand_chk_pkg.sv
// Shared types, constants and the reference NAND-network function for the response checker.
package nand_chk_pkg;

    localparam int CNT_W = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [5:0] nand_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } chk_state_t;

    // Bit order is {A,B,C,D,E,F}; E does not influence the response.
    function automatic logic golden_exp(input nand_vec_t v);
        return (v[5] & v[4]) | (v[3] & ~v[0]) | (~v[2] & ~v[0]);
    endfunction

endpackage

// File: rtl/nand_golden_model.sv
// Combinational expected-response generator for one stimulus vector.
module nand_golden_model
    import nand_chk_pkg::*;
(
    input  logic [5:0] vec,
    output logic       exp_g
);

    assign exp_g = golden_exp(nand_vec_t'(vec));

endmodule

// File: rtl/nand_resp_checker.sv
// Counts accepted vectors and mismatches against the golden model over one run.
// Optional first-mismatch capture is enabled by defining MISMATCH_CAPTURE_EN.
module nand_resp_checker
    import nand_chk_pkg::*;
#(
    parameter int NUM_VECTORS = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       vec_valid,
    input  logic [5:0] vec,
    input  logic       dut_g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] checked_cnt,
    output logic [6:0] err_cnt,
    output logic       first_err_valid,
    output logic [5:0] first_err_vec,
    output logic       first_err_g
);

    localparam logic [CNT_W-1:0] RUN_LEN = CNT_W'(NUM_VECTORS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    chk_state_t       state, state_nx;
    logic [CNT_W-1:0] chk_nx, err_nx;
    logic             exp_g;
    logic             accept, mismatch, clear_run;

    nand_golden_model u_golden (
        .vec   (vec),
        .exp_g (exp_g)
    );

    assign accept    = (state == ST_RUN) && vec_valid;
    assign mismatch  = accept && (dut_g != exp_g);
    assign clear_run = (state != ST_RUN) && start;

    always_comb begin
        state_nx = state;
        chk_nx   = checked_cnt;
        err_nx   = err_cnt;
        if (clear_run) begin
            state_nx = ST_RUN;
            chk_nx   = '0;
            err_nx   = '0;
        end else if (accept) begin
            chk_nx = checked_cnt + CNT_W'(1);
            if (mismatch)
                err_nx = sat_inc(err_cnt);
            if (chk_nx == RUN_LEN)
                state_nx = ST_DONE;
        end
    end

    // Status flags are decoded from the next state so they line up with the counts.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            checked_cnt <= '0;
            err_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            state       <= state_nx;
            checked_cnt <= chk_nx;
            err_cnt     <= err_nx;
            busy        <= (state_nx == ST_RUN);
            done        <= (state_nx == ST_DONE);
            pass        <= (state_nx == ST_DONE) && (err_nx == '0);
        end
    end

`ifdef MISMATCH_CAPTURE_EN
    always_ff @(posedge clock) begin
        if (reset || clear_run) begin
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            first_err_g     <= 1'b0;
        end else if (mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_vec   <= vec;
            first_err_g     <= dut_g;
        end
    end
`else
    assign first_err_valid = 1'b0;
    assign first_err_vec   = '0;
    assign first_err_g     = 1'b0;
`endif

endmodule
